// File: rtl/pcap_pkg.sv
// Shared definitions for the pcap replay / header extraction path.
package pcap_pkg;

    localparam logic [15:0] ETYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  IPPROTO_TCP = 8'd6;
    localparam logic [7:0]  IPPROTO_UDP = 8'd17;

    // Parser walk through the layered headers of one frame.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ETH,
        ST_VLAN,
        ST_IP,
        ST_L4,
        ST_SKIP
    } pstate_t;

    // One extracted header record.
    typedef struct packed {
        logic [47:0] eth_dst;
        logic [47:0] eth_src;
        logic [15:0] eth_type;
        logic        vlan_present;
        logic [11:0] vlan_id;
        logic        ip_valid;
        logic [7:0]  ip_proto;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic        l4_valid;
        logic [15:0] l4_sport;
        logic [15:0] l4_dport;
    } hdr_rec_t;

    // Protocols whose port pair we extract.
    function automatic logic is_l4_proto(input logic [7:0] p);
        return (p == IPPROTO_TCP) || (p == IPPROTO_UDP);
    endfunction

endpackage

// File: rtl/eth_hdr_extract.sv
// Byte-serial Ethernet / 802.1Q / IPv4 / TCP-UDP header extractor.
// Fields are shifted into shadow registers as bytes arrive; the output
// record is loaded from the shadows only on the cycle hdr_valid pulses.
module eth_hdr_extract
    import pcap_pkg::*;
#(
    parameter logic [15:0] VLAN_TPID = 16'h8100,
    parameter int          COUNT_W   = 16
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [7:0]         in_data,
    input  logic               in_eos,
    output logic               hdr_valid,
    output logic               hdr_trunc,
    output logic [47:0]        eth_dst,
    output logic [47:0]        eth_src,
    output logic [15:0]        eth_type,
    output logic               vlan_present,
    output logic [11:0]        vlan_id,
    output logic               ip_valid,
    output logic [7:0]         ip_proto,
    output logic [31:0]        ip_src,
    output logic [31:0]        ip_dst,
    output logic               l4_valid,
    output logic [15:0]        l4_sport,
    output logic [15:0]        l4_dport,
    output logic [COUNT_W-1:0] frame_count
);

    pstate_t      state_q, state_d;
    logic [5:0]   off_q, off_d;       // byte offset within the current layer
    hdr_rec_t     sh_q, sh_d;         // shadow record being assembled
    hdr_rec_t     rec_q, rec_d;       // published record
    logic [3:0]   ihl_q, ihl_d;
    logic [12:0]  frag_q, frag_d;
    logic         emit_d, trunc_d, done;
    logic         vld_q, trunc_q;
    logic [COUNT_W-1:0] cnt_q;
    logic         busy;
    logic [5:0]   ip_last;
    hdr_rec_t     trunc_rec;

    // A frame is "busy" until its record has been completed.
    assign busy    = (state_q == ST_ETH) || (state_q == ST_VLAN) ||
                     (state_q == ST_IP)  || (state_q == ST_L4);
    assign ip_last = {ihl_q, 2'b00} - 6'd1;

    // Truncated record: layers not yet finished report invalid.
    always_comb begin
        trunc_rec          = sh_q;
        trunc_rec.l4_valid = 1'b0;
        if (state_q != ST_L4)
            trunc_rec.ip_valid = 1'b0;
    end

    // Next-state, shadow accumulation and record emission.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        sh_d    = sh_q;
        ihl_d   = ihl_q;
        frag_d  = frag_q;
        rec_d   = rec_q;
        emit_d  = 1'b0;
        trunc_d = 1'b0;
        done    = 1'b0;
        if (in_valid && off_q != 6'h3f)
            off_d = off_q + 6'd1;

        if (in_valid && in_sof) begin
            // Restart on sof; an unfinished frame gets a truncated record.
            if (busy) begin
                emit_d  = 1'b1;
                trunc_d = 1'b1;
                rec_d   = trunc_rec;
            end
            sh_d         = '0;
            sh_d.eth_dst = {40'd0, in_data};
            ihl_d        = '0;
            frag_d       = '0;
            state_d      = ST_ETH;
            off_d        = 6'd1;
        end else if (in_eos) begin
            if (busy) begin
                emit_d  = 1'b1;
                trunc_d = 1'b1;
                rec_d   = trunc_rec;
            end
            state_d = ST_IDLE;
            off_d   = '0;
        end else if (in_valid) begin
            case (state_q)
                ST_ETH: begin
                    if (off_q < 6'd6)
                        sh_d.eth_dst = {sh_q.eth_dst[39:0], in_data};
                    else if (off_q < 6'd12)
                        sh_d.eth_src = {sh_q.eth_src[39:0], in_data};
                    else
                        sh_d.eth_type = {sh_q.eth_type[7:0], in_data};
                    if (off_q == 6'd13) begin
                        off_d = '0;
                        if (sh_d.eth_type == VLAN_TPID)
                            state_d = ST_VLAN;
                        else if (sh_d.eth_type == ETYPE_IPV4)
                            state_d = ST_IP;
                        else
                            done = 1'b1;
                    end
                end
                ST_VLAN: begin
                    // TCI then the inner ethertype, which replaces the TPID.
                    if (off_q < 6'd2)
                        sh_d.vlan_id = {sh_q.vlan_id[3:0], in_data};
                    else
                        sh_d.eth_type = {sh_q.eth_type[7:0], in_data};
                    if (off_q == 6'd3) begin
                        sh_d.vlan_present = 1'b1;
                        off_d = '0;
                        if (sh_d.eth_type == ETYPE_IPV4)
                            state_d = ST_IP;
                        else
                            done = 1'b1;
                    end
                end
                ST_IP: begin
                    if (off_q == 6'd0) begin
                        ihl_d = in_data[3:0];
                        if (in_data[7:4] != 4'd4 || in_data[3:0] < 4'd5)
                            done = 1'b1;
                    end else if (off_q == 6'd6 || off_q == 6'd7) begin
                        frag_d = {frag_q[4:0], in_data};
                    end else if (off_q == 6'd9) begin
                        sh_d.ip_proto = in_data;
                    end else if (off_q >= 6'd12 && off_q < 6'd16) begin
                        sh_d.ip_src = {sh_q.ip_src[23:0], in_data};
                    end else if (off_q >= 6'd16 && off_q < 6'd20) begin
                        sh_d.ip_dst = {sh_q.ip_dst[23:0], in_data};
                    end
                    // Options beyond byte 19 fall through untouched.
                    if (off_q != 6'd0 && off_q == ip_last) begin
                        sh_d.ip_valid = 1'b1;
                        off_d = '0;
                        if (is_l4_proto(sh_q.ip_proto) && frag_q == '0)
                            state_d = ST_L4;
                        else
                            done = 1'b1;
                    end
                end
                ST_L4: begin
                    if (off_q < 6'd2)
                        sh_d.l4_sport = {sh_q.l4_sport[7:0], in_data};
                    else
                        sh_d.l4_dport = {sh_q.l4_dport[7:0], in_data};
                    if (off_q == 6'd3) begin
                        sh_d.l4_valid = 1'b1;
                        done = 1'b1;
                    end
                end
                default: ;
            endcase
            if (done) begin
                emit_d  = 1'b1;
                rec_d   = sh_d;
                state_d = ST_SKIP;
                off_d   = '0;
            end
        end
    end

    // Parser state, offset and shadow registers.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            off_q   <= '0;
            sh_q    <= '0;
            ihl_q   <= '0;
            frag_q  <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            sh_q    <= sh_d;
            ihl_q   <= ihl_d;
            frag_q  <= frag_d;
        end
    end

    // Published record, pulse and frame counter.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rec_q   <= '0;
            vld_q   <= 1'b0;
            trunc_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            vld_q <= emit_d;
            if (emit_d) begin
                rec_q   <= rec_d;
                trunc_q <= trunc_d;
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

    assign hdr_valid    = vld_q;
    assign hdr_trunc    = trunc_q;
    assign eth_dst      = rec_q.eth_dst;
    assign eth_src      = rec_q.eth_src;
    assign eth_type     = rec_q.eth_type;
    assign vlan_present = rec_q.vlan_present;
    assign vlan_id      = rec_q.vlan_id;
    assign ip_valid     = rec_q.ip_valid;
    assign ip_proto     = rec_q.ip_proto;
    assign ip_src       = rec_q.ip_src;
    assign ip_dst       = rec_q.ip_dst;
    assign l4_valid     = rec_q.l4_valid;
    assign l4_sport     = rec_q.l4_sport;
    assign l4_dport     = rec_q.l4_dport;
    assign frame_count  = cnt_q;

endmodule

// File: tb/tb_eth_hdr_extract.sv
// Directed bench for eth_hdr_extract.
module tb_eth_hdr_extract;
    import pcap_pkg::*;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        in_valid = 1'b0, in_sof = 1'b0, in_eos = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        hdr_valid, hdr_trunc, vlan_present, ip_valid, l4_valid;
    logic [47:0] eth_dst, eth_src;
    logic [15:0] eth_type, l4_sport, l4_dport, frame_count;
    logic [11:0] vlan_id;
    logic [7:0]  ip_proto;
    logic [31:0] ip_src, ip_dst;

    eth_hdr_extract #(.VLAN_TPID(16'h8100), .COUNT_W(16)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .in_eos(in_eos), .hdr_valid(hdr_valid),
        .hdr_trunc(hdr_trunc), .eth_dst(eth_dst), .eth_src(eth_src),
        .eth_type(eth_type), .vlan_present(vlan_present), .vlan_id(vlan_id),
        .ip_valid(ip_valid), .ip_proto(ip_proto), .ip_src(ip_src),
        .ip_dst(ip_dst), .l4_valid(l4_valid), .l4_sport(l4_sport),
        .l4_dport(l4_dport), .frame_count(frame_count)
    );

    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    typedef struct {
        hdr_rec_t    r;
        logic        trunc;
        int          cyc;
        logic [15:0] cnt;
    } cap_t;
    cap_t caps[$];

    // Capture every record pulse, away from the active edge.
    always @(negedge CLOCK) begin
        if (hdr_valid === 1'b1) begin
            cap_t c;
            c.r.eth_dst = eth_dst;   c.r.eth_src = eth_src;
            c.r.eth_type = eth_type; c.r.vlan_present = vlan_present;
            c.r.vlan_id = vlan_id;   c.r.ip_valid = ip_valid;
            c.r.ip_proto = ip_proto; c.r.ip_src = ip_src;
            c.r.ip_dst = ip_dst;     c.r.l4_valid = l4_valid;
            c.r.l4_sport = l4_sport; c.r.l4_dport = l4_dport;
            c.trunc = hdr_trunc; c.cyc = cyc; c.cnt = frame_count;
            caps.push_back(c);
        end
    end

    logic [7:0] fr[$];
    int         acc[$];
    int         n_chk = 0, n_fail = 0;

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLOCK);
            in_valid = 1'b0; in_sof = 1'b0; in_eos = 1'b0;
        end
    endtask

    task automatic put(input logic [7:0] d, input logic sof);
        @(negedge CLOCK);
        in_valid = 1'b1; in_sof = sof; in_data = d; in_eos = 1'b0;
        acc.push_back(cyc + 1);
    endtask

    // Send bytes 0..last of fr; optional 5-on/5-off pause pattern.
    task automatic send(input int last, input bit pause);
        acc.delete();
        for (int i = 0; i <= last; i++) begin
            if (pause && i > 0 && (i % 5) == 0) idle(5);
            put(fr[i], i == 0);
        end
        idle(1);
    endtask

    task automatic mk(input logic [47:0] dst, input logic [47:0] src,
                      input bit vl, input logic [15:0] tci,
                      input logic [15:0] etype, input logic [3:0] ihl,
                      input logic [7:0] proto, input logic [15:0] frag,
                      input logic [31:0] ips, input logic [31:0] ipd,
                      input logic [15:0] sp, input logic [15:0] dp,
                      input int len);
        fr.delete();
        for (int i = 5; i >= 0; i--) fr.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fr.push_back(src[8*i +: 8]);
        if (vl) begin
            fr.push_back(8'h81); fr.push_back(8'h00);
            fr.push_back(tci[15:8]); fr.push_back(tci[7:0]);
        end
        fr.push_back(etype[15:8]); fr.push_back(etype[7:0]);
        if (etype == 16'h0800) begin
            fr.push_back({4'h4, ihl}); fr.push_back(8'h00);
            fr.push_back(8'h00); fr.push_back(8'h28);
            fr.push_back(8'h12); fr.push_back(8'h34);
            fr.push_back(frag[15:8]); fr.push_back(frag[7:0]);
            fr.push_back(8'h40); fr.push_back(proto);
            fr.push_back(8'h00); fr.push_back(8'h00);
            for (int i = 3; i >= 0; i--) fr.push_back(ips[8*i +: 8]);
            for (int i = 3; i >= 0; i--) fr.push_back(ipd[8*i +: 8]);
            for (int k = 20; k < 4 * int'(ihl); k++) fr.push_back(8'hAA);
            fr.push_back(sp[15:8]); fr.push_back(sp[7:0]);
            fr.push_back(dp[15:8]); fr.push_back(dp[7:0]);
        end
        while (fr.size() < len) fr.push_back(8'h5A);
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        idle(3);
        RESET = 1'b0;
        idle(2);
        n_chk++; if (hdr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hdr_valid: got %b expected 0", hdr_valid); end
        n_chk++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", frame_count); end
        n_chk++; if (eth_dst !== 48'd0 || ip_src !== 32'd0 || l4_dport !== 16'd0) begin n_fail++; $display("FAIL reset_fields: got %h %h %h expected 0", eth_dst, ip_src, l4_dport); end
        n_chk++; if (ip_valid !== 1'b0 || l4_valid !== 1'b0 || hdr_trunc !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b%b expected 000", ip_valid, l4_valid, hdr_trunc); end
    endtask

    task automatic test_tcp;
        caps.delete();
        mk(48'h001122334455, 48'h66778899aabb, 1'b0, 16'h0, 16'h0800, 4'd5, 8'd6,
           16'h0, 32'h0a000001, 32'h0a000002, 16'd1234, 16'd80, 60);
        send(59, 1'b0);
        idle(4);
        n_chk++; if (caps.size() !== 1) begin n_fail++; $display("FAIL tcp_pulses: got %0d expected 1", caps.size()); end
        if (caps.size() >= 1) begin
            n_chk++; if (caps[0].cyc !== acc[37]) begin n_fail++; $display("FAIL tcp_latency: got cycle %0d expected %0d", caps[0].cyc, acc[37]); end
            n_chk++; if (caps[0].r.eth_dst !== 48'h001122334455 || caps[0].r.eth_src !== 48'h66778899aabb) begin n_fail++; $display("FAIL tcp_macs: got %h %h expected 001122334455 66778899aabb", caps[0].r.eth_dst, caps[0].r.eth_src); end
            n_chk++; if (caps[0].r.eth_type !== 16'h0800 || caps[0].r.vlan_present !== 1'b0) begin n_fail++; $display("FAIL tcp_type: got %h %b expected 0800 0", caps[0].r.eth_type, caps[0].r.vlan_present); end
            n_chk++; if (caps[0].r.ip_src !== 32'h0a000001 || caps[0].r.ip_dst !== 32'h0a000002 || caps[0].r.ip_proto !== 8'd6) begin n_fail++; $display("FAIL tcp_ip: got %h %h %0d expected 0a000001 0a000002 6", caps[0].r.ip_src, caps[0].r.ip_dst, caps[0].r.ip_proto); end
            n_chk++; if (caps[0].r.l4_sport !== 16'd1234 || caps[0].r.l4_dport !== 16'd80) begin n_fail++; $display("FAIL tcp_ports: got %0d %0d expected 1234 80", caps[0].r.l4_sport, caps[0].r.l4_dport); end
            n_chk++; if (caps[0].r.ip_valid !== 1'b1 || caps[0].r.l4_valid !== 1'b1 || caps[0].trunc !== 1'b0) begin n_fail++; $display("FAIL tcp_flags: got ip%b l4%b tr%b expected 1 1 0", caps[0].r.ip_valid, caps[0].r.l4_valid, caps[0].trunc); end
            n_chk++; if (caps[0].cnt !== 16'd1) begin n_fail++; $display("FAIL tcp_count: got %0d expected 1", caps[0].cnt); end
        end
        n_chk++; if (l4_dport !== 16'd80 || hdr_valid !== 1'b0) begin n_fail++; $display("FAIL tcp_hold: got %0d %b expected 80 0", l4_dport, hdr_valid); end
    endtask

    task automatic test_vlan;
        caps.delete();
        mk(48'h0a0b0c0d0e0f, 48'h102030405060, 1'b1, 16'h0064, 16'h0800, 4'd5, 8'd17,
           16'h0, 32'hc0000201, 32'hc0000202, 16'd53, 16'd5353, 64);
        send(63, 1'b0);
        idle(4);
        n_chk++; if (caps.size() !== 1) begin n_fail++; $display("FAIL vlan_pulses: got %0d expected 1", caps.size()); end
        if (caps.size() >= 1) begin
            n_chk++; if (caps[0].cyc !== acc[41]) begin n_fail++; $display("FAIL vlan_latency: got cycle %0d expected %0d", caps[0].cyc, acc[41]); end
            n_chk++; if (caps[0].r.vlan_present !== 1'b1 || caps[0].r.vlan_id !== 12'd100) begin n_fail++; $display("FAIL vlan_tag: got %b %0d expected 1 100", caps[0].r.vlan_present, caps[0].r.vlan_id); end
            n_chk++; if (caps[0].r.eth_type !== 16'h0800) begin n_fail++; $display("FAIL vlan_etype: got %h expected 0800", caps[0].r.eth_type); end
            n_chk++; if (caps[0].r.l4_sport !== 16'd53 || caps[0].r.l4_dport !== 16'd5353 || caps[0].r.l4_valid !== 1'b1) begin n_fail++; $display("FAIL vlan_ports: got %0d %0d %b expected 53 5353 1", caps[0].r.l4_sport, caps[0].r.l4_dport, caps[0].r.l4_valid); end
            n_chk++; if (caps[0].cnt !== 16'd2) begin n_fail++; $display("FAIL vlan_count: got %0d expected 2", caps[0].cnt); end
        end
    endtask

    task automatic test_ihl6_pause;
        mk(48'h020000000001, 48'h020000000002, 1'b0, 16'h0, 16'h0800, 4'd6, 8'd17,
           16'h4000, 32'hc0a80101, 32'hc0a80102, 16'd1000, 16'd2000, 64);
        for (int p = 0; p < 2; p++) begin
            caps.delete();
            send(63, p == 1);
            idle(4);
            n_chk++; if (caps.size() !== 1) begin n_fail++; $display("FAIL ihl6_pulses[%0d]: got %0d expected 1", p, caps.size()); end
            if (caps.size() >= 1) begin
                n_chk++; if (caps[0].cyc !== acc[41]) begin n_fail++; $display("FAIL ihl6_latency[%0d]: got cycle %0d expected %0d", p, caps[0].cyc, acc[41]); end
                n_chk++; if (caps[0].r.l4_sport !== 16'd1000 || caps[0].r.l4_dport !== 16'd2000) begin n_fail++; $display("FAIL ihl6_ports[%0d]: got %0d %0d expected 1000 2000", p, caps[0].r.l4_sport, caps[0].r.l4_dport); end
                n_chk++; if (caps[0].r.ip_src !== 32'hc0a80101 || caps[0].r.ip_dst !== 32'hc0a80102 || caps[0].r.ip_proto !== 8'd17) begin n_fail++; $display("FAIL ihl6_ip[%0d]: got %h %h %0d expected c0a80101 c0a80102 17", p, caps[0].r.ip_src, caps[0].r.ip_dst, caps[0].r.ip_proto); end
                n_chk++; if (caps[0].r.ip_valid !== 1'b1 || caps[0].r.l4_valid !== 1'b1) begin n_fail++; $display("FAIL ihl6_flags[%0d]: got %b %b expected 1 1", p, caps[0].r.ip_valid, caps[0].r.l4_valid); end
            end
        end
    endtask

    task automatic test_arp;
        caps.delete();
        mk(48'hffffffffffff, 48'h66778899aabb, 1'b0, 16'h0, 16'h0806, 4'd5, 8'd0,
           16'h0, 32'h0, 32'h0, 16'd0, 16'd0, 60);
        send(59, 1'b0);
        idle(4);
        n_chk++; if (caps.size() !== 1) begin n_fail++; $display("FAIL arp_pulses: got %0d expected 1", caps.size()); end
        if (caps.size() >= 1) begin
            n_chk++; if (caps[0].cyc !== acc[13]) begin n_fail++; $display("FAIL arp_latency: got cycle %0d expected %0d", caps[0].cyc, acc[13]); end
            n_chk++; if (caps[0].r.eth_type !== 16'h0806 || caps[0].r.ip_valid !== 1'b0 || caps[0].r.l4_valid !== 1'b0) begin n_fail++; $display("FAIL arp_fields: got %h %b %b expected 0806 0 0", caps[0].r.eth_type, caps[0].r.ip_valid, caps[0].r.l4_valid); end
            n_chk++; if (caps[0].trunc !== 1'b0 || caps[0].cnt !== 16'd5) begin n_fail++; $display("FAIL arp_trunc_count: got %b %0d expected 0 5", caps[0].trunc, caps[0].cnt); end
        end
    endtask

    task automatic test_trunc_sof;
        caps.delete();
        mk(48'h001122334455, 48'h66778899aabb, 1'b0, 16'h0, 16'h0800, 4'd5, 8'd6,
           16'h0, 32'h0a000001, 32'h0a000002, 16'd1234, 16'd80, 60);
        send(19, 1'b0);
        mk(48'h0c0c0c0c0c0c, 48'h0d0d0d0d0d0d, 1'b0, 16'h0, 16'h0800, 4'd5, 8'd6,
           16'h0, 32'h01020304, 32'h05060708, 16'd4321, 16'd443, 60);
        send(59, 1'b0);
        idle(4);
        n_chk++; if (caps.size() !== 2) begin n_fail++; $display("FAIL trunc_pulses: got %0d expected 2", caps.size()); end
        if (caps.size() >= 2) begin
            n_chk++; if (caps[0].cyc !== acc[0]) begin n_fail++; $display("FAIL trunc_latency: got cycle %0d expected %0d", caps[0].cyc, acc[0]); end
            n_chk++; if (caps[0].trunc !== 1'b1 || caps[0].r.ip_valid !== 1'b0 || caps[0].r.l4_valid !== 1'b0) begin n_fail++; $display("FAIL trunc_flags: got tr%b ip%b l4%b expected 1 0 0", caps[0].trunc, caps[0].r.ip_valid, caps[0].r.l4_valid); end
            n_chk++; if (caps[0].r.eth_dst !== 48'h001122334455 || caps[0].r.eth_src !== 48'h66778899aabb || caps[0].r.eth_type !== 16'h0800) begin n_fail++; $display("FAIL trunc_eth: got %h %h %h expected 001122334455 66778899aabb 0800", caps[0].r.eth_dst, caps[0].r.eth_src, caps[0].r.eth_type); end
            n_chk++; if (caps[1].trunc !== 1'b0 || caps[1].r.ip_src !== 32'h01020304 || caps[1].r.l4_sport !== 16'd4321 || caps[1].r.l4_dport !== 16'd443) begin n_fail++; $display("FAIL trunc_next: got %b %h %0d %0d expected 0 01020304 4321 443", caps[1].trunc, caps[1].r.ip_src, caps[1].r.l4_sport, caps[1].r.l4_dport); end
            n_chk++; if (caps[1].cnt !== 16'd7) begin n_fail++; $display("FAIL trunc_count: got %0d expected 7", caps[1].cnt); end
        end
    endtask

    task automatic test_eos;
        caps.delete();
        mk(48'h001122334455, 48'h66778899aabb, 1'b0, 16'h0, 16'h0800, 4'd5, 8'd6,
           16'h0, 32'h0a000001, 32'h0a000002, 16'd1234, 16'd80, 60);
        send(7, 1'b0);
        @(negedge CLOCK); in_eos = 1'b1;
        idle(4);
        n_chk++; if (caps.size() !== 1) begin n_fail++; $display("FAIL eos_pulses: got %0d expected 1", caps.size()); end
        if (caps.size() >= 1) begin
            n_chk++; if (caps[0].trunc !== 1'b1 || caps[0].r.eth_dst !== 48'h001122334455 || caps[0].r.eth_type !== 16'h0000 || caps[0].r.ip_valid !== 1'b0) begin n_fail++; $display("FAIL eos_record: got %b %h %h %b expected 1 001122334455 0000 0", caps[0].trunc, caps[0].r.eth_dst, caps[0].r.eth_type, caps[0].r.ip_valid); end
            n_chk++; if (caps[0].cnt !== 16'd8) begin n_fail++; $display("FAIL eos_count: got %0d expected 8", caps[0].cnt); end
        end
        // A second end-of-stream while idle must not produce a record.
        @(negedge CLOCK); in_eos = 1'b1;
        idle(4);
        n_chk++; if (caps.size() !== 1) begin n_fail++; $display("FAIL eos_idle: got %0d records expected 1", caps.size()); end
    endtask

    task automatic test_reset_mid;
        caps.delete();
        mk(48'h001122334455, 48'h66778899aabb, 1'b0, 16'h0, 16'h0800, 4'd5, 8'd6,
           16'h0, 32'h0a000001, 32'h0a000002, 16'd1234, 16'd80, 60);
        send(9, 1'b0);
        @(negedge CLOCK); RESET = 1'b1; in_valid = 1'b0;
        @(negedge CLOCK); RESET = 1'b0;
        send(59, 1'b0);
        idle(4);
        n_chk++; if (caps.size() !== 1) begin n_fail++; $display("FAIL rstmid_pulses: got %0d expected 1", caps.size()); end
        n_chk++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 1", frame_count); end
        if (caps.size() >= 1) begin
            n_chk++; if (caps[0].trunc !== 1'b0 || caps[0].r.l4_valid !== 1'b1 || caps[0].r.l4_sport !== 16'd1234) begin n_fail++; $display("FAIL rstmid_record: got %b %b %0d expected 0 1 1234", caps[0].trunc, caps[0].r.l4_valid, caps[0].r.l4_sport); end
        end
    endtask

    initial begin
        test_reset();
        test_tcp();
        test_vlan();
        test_ihl6_pause();
        test_arp();
        test_trunc_sof();
        test_eos();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_hdr_extract.md
# eth_hdr_extract

Downstream consumer of the pcap replay byte stream. Takes one byte per valid cycle, frame-delimited by a start-of-frame flag, and walks the Ethernet / optional 802.1Q / IPv4 / TCP-UDP headers. It emits one registered header record per frame: MACs, ethertype, VLAN, IPv4 addresses, protocol and L4 ports. It sits between the pcap replay source and the flow-matching logic.

## Interface
- VLAN_TPID, 16'h8100, TPID recognised as a single VLAN tag
- COUNT_W, 16, width of frame_count
- CLOCK  in  1  sole clock, all logic on rising edge
- RESET  in  1  synchronous, active-high
- in_valid  in  1  in_data carries a byte this cycle
- in_sof  in  1  first byte of a frame; qualified by in_valid
- in_data  in  8  stream byte
- in_eos  in  1  end of stream pulse; pcapfinished rising edge in the replay path
- hdr_valid  out  1  one-cycle pulse, record below is new
- hdr_trunc  out  1  frame ended before parse completed; valid with hdr_valid
- eth_dst, eth_src  out  48 each  MAC addresses, first wire byte in MSBs
- eth_type  out  16  ethertype after any VLAN tag
- vlan_present  out  1;  vlan_id  out  12
- ip_valid  out  1  IPv4 with version 4 and IHL ≥ 5 parsed through its full IHL
- ip_proto  out  8;  ip_src, ip_dst  out  32 each
- l4_valid  out  1  TCP (6) or UDP (17), fragment offset 0, ports parsed
- l4_sport, l4_dport  out  16 each
- frame_count  out  COUNT_W  number of hdr_valid pulses since reset; wraps

## Operation
- States:
  - IDLE: waits for sof.
  - ETH: bytes 0–13.
  - VLAN: 4 bytes.
  - IP: IHL*4 bytes.
  - L4: 4 bytes.
  - SKIP: discards the rest of the frame.
- Byte-offset counter (6 bits) advances only on in_valid; in_valid low cycles (pause) are ignored in every state.
- Sequencing:
  - ETH: bytes 12–13 equal VLAN_TPID → VLAN. That tag's TCI low 12 bits → vlan_id; its last 2 bytes → eth_type. A second tag is not unwrapped.
  - eth_type 16'h0800 → IP; otherwise record complete → SKIP.
  - IP byte 0: version ≠ 4 or IHL < 5 → ip_valid=0, record complete.
  - IP bytes 6–7: frag offset = low 13 bits. Byte 9 → proto; 12–15 → src; 16–19 → dst. Option bytes 20..IHL*4-1 are skipped.
  - After IP: proto is 6 or 17 and frag offset = 0 → L4; otherwise complete.
  - L4 bytes 0–1 → sport; 2–3 → dport; complete.
- Fields accumulate in shadow registers. Outputs are loaded from the shadows only on the hdr_valid cycle and are stable between pulses.
- in_sof (with in_valid) in any state restarts the parse with that byte as offset 0.
  - If the previous frame had not completed (state not IDLE/SKIP), a truncated record is emitted: hdr_trunc=1, with validity flags for unfinished layers forced to 0.
- in_eos in an incomplete state → truncated record, then IDLE. In IDLE/SKIP → IDLE, no record.
- Frames shorter than 14 bytes → truncated record with ip_valid=l4_valid=0.

## Timing
- hdr_valid asserts in the cycle after the completing byte is accepted (1-cycle latency). Also the cycle after a sof/eos that truncates.
- At most one hdr_valid per cycle. A truncation and a new frame never collide, because a new frame cannot complete on its first byte.
- in_sof together with in_eos in the same cycle: truncation is emitted for the old frame, the sof byte starts the new frame, and in_eos is ignored.
- Reset values: state IDLE, all outputs 0, frame_count 0. RESET mid-frame discards the shadows and emits no record.
- Maximum header length 14+4+60+4 = 82 bytes; the offset counter saturates in SKIP.

## Structure
- Shared package pcap_pkg holds:
  - ETYPE_IPV4 = 16'h0800
  - IPPROTO_TCP = 6, IPPROTO_UDP = 17
  - parser state enum
- Single module; no sub-module required. The byte shift-into-field logic is inline, indexed by the offset counter.

## Test plan
- Untagged TCP frame (dst 00:11:22:33:44:55, src 66:77:88:99:aa:bb, 10.0.0.1:1234 → 10.0.0.2:80, IHL 5):
  - hdr_valid exactly 1 cycle after byte 37.
  - Fields match; ip_valid=l4_valid=1; frame_count=1.
- VLAN 0x8100 TCI 0x0064, inner 0x0800, UDP 53→5353 → vlan_present=1, vlan_id=100, eth_type=0x0800, l4_dport=5353.
- IPv4 IHL=6 (4 option bytes), UDP → ports taken from IP bytes 24–27; pause toggling every 5 cycles yields identical fields.
- ARP frame (0x0806), 60 bytes → hdr_valid after byte 13, ip_valid=0, and no further pulse until the next sof.
- in_sof arrives at byte 20 of an IPv4 frame → hdr_trunc=1, ip_valid=0, with eth fields intact. The new frame then parses normally.
- RESET asserted at byte 10, then a full frame → exactly one hdr_valid, frame_count=1.
